// File: rtl/polaris_ifetch_queue.sv
// Instruction prefetch queue: runs ahead on the I bus, buffers tagged words.
// clk_i/reset_i; I bus (istb/iadr/isiz/iack/idat); redirect; head + count out.
module polaris_ifetch_queue #(
  parameter int          XLEN      = 64,
  parameter int          DEPTH     = 4,
  parameter logic [63:0] RESET_VEC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     iack_i,
  input  logic [31:0]              idat_i,
  output logic                     istb_o,
  output logic [XLEN-1:0]          iadr_o,
  output logic [1:0]               isiz_o,
  input  logic                     redir_i,
  input  logic [XLEN-1:0]          redir_adr_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              inst_o,
  output logic [XLEN-1:0]          inst_adr_o,
  output logic                     inst_fault_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] RV   = RESET_VEC[XLEN-1:0];

  typedef enum logic {FETCH, HALT} st_t;

  st_t             r_state;
  logic [XLEN-1:0] r_fpc;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_dat [DEPTH];
  logic [XLEN-1:0] r_adr [DEPTH];
  logic [DEPTH-1:0] r_flt;

  logic w_go;
  logic w_aln;
  logic w_stb;
  logic w_enq_bus;
  logic w_enq_flt;
  logic w_enq;
  logic w_valid;
  logic w_deq;

  // Fetch may start only on registered occupancy; redirect and reset
  // kill the strobe in the same cycle so no ack can be half-taken.
  assign w_aln     = (r_fpc[1:0] == 2'b00);
  assign w_go      = (r_state == FETCH) & (r_count < FULL)
                   & ~redir_i & ~reset_i;
  assign w_stb     = w_go & w_aln;
  assign w_enq_bus = w_stb & iack_i;
  // A misaligned target becomes a queued fault instead of a bus cycle.
  assign w_enq_flt = w_go & ~w_aln;
  assign w_enq     = w_enq_bus | w_enq_flt;
  assign w_valid   = (r_count != '0);
  assign w_deq     = w_valid & inst_ready_i;

  assign istb_o       = w_stb;
  assign iadr_o       = w_stb ? r_fpc : '0;
  assign isiz_o       = w_stb ? 2'b10 : 2'b00;
  assign inst_valid_o = w_valid;
  assign inst_fault_o = w_valid & r_flt[r_rd];
  assign inst_o       = (w_valid & ~r_flt[r_rd]) ? r_dat[r_rd] : '0;
  assign inst_adr_o   = w_valid ? r_adr[r_rd] : '0;
  assign count_o      = r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= FETCH;
      r_fpc   <= RV;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (redir_i) begin
      r_state <= FETCH;
      r_fpc   <= redir_adr_i;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_dat[r_wr] <= w_enq_bus ? idat_i : '0;
        r_adr[r_wr] <= r_fpc;
        r_flt[r_wr] <= w_enq_flt;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_enq_bus) begin
        r_fpc <= r_fpc + XLEN'(4);
      end
      if (w_enq_flt) begin
        r_state <= HALT;
      end
      if (w_deq) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_enq & ~w_deq) begin
        r_count <= r_count + CW'(1);
      end else if (~w_enq & w_deq) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_polaris_ifetch_queue.sv
// Bench for polaris_ifetch_queue: directed vector table, queue-based
// reference model under random traffic, and a 32-bit wrap instance.
module tb_polaris_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        iack_i = 1'b0;
  logic [31:0] idat_i = '0;
  logic        istb_o;
  logic [63:0] iadr_o;
  logic [1:0]  isiz_o;
  logic        redir_i = 1'b0;
  logic [63:0] redir_adr_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] inst_adr_o;
  logic        inst_fault_o;
  logic [2:0]  count_o;

  logic        istb32;
  logic [31:0] iadr32;
  logic [1:0]  isiz32;
  logic        val32;
  logic [31:0] inst32;
  logic [31:0] adr32;
  logic        flt32;
  logic [1:0]  cnt32;

  always #5 clk = ~clk;

  polaris_ifetch_queue dut (
    .clk_i(clk), .reset_i(reset_i), .iack_i(iack_i), .idat_i(idat_i),
    .istb_o(istb_o), .iadr_o(iadr_o), .isiz_o(isiz_o),
    .redir_i(redir_i), .redir_adr_i(redir_adr_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_adr_o(inst_adr_o),
    .inst_fault_o(inst_fault_o), .count_o(count_o)
  );

  polaris_ifetch_queue #(
    .XLEN(32), .DEPTH(2), .RESET_VEC(64'hFFFF_FFFC)
  ) dut32 (
    .clk_i(clk), .reset_i(reset_i), .iack_i(1'b1),
    .idat_i(32'h0000_0013),
    .istb_o(istb32), .iadr_o(iadr32), .isiz_o(isiz32),
    .redir_i(1'b0), .redir_adr_i(32'h0),
    .inst_valid_o(val32), .inst_ready_i(1'b0),
    .inst_o(inst32), .inst_adr_o(adr32),
    .inst_fault_o(flt32), .count_o(cnt32)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [63:0] a;
    logic        f;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mfpc;
  bit          mhalt;

  task automatic model_reset();
    mq.delete();
    mfpc  = 64'hFFFF_FFFF_FFFF_FF00;
    mhalt = 0;
  endtask

  // One clock: drive at negedge, compare against the model, then
  // advance the model by what the coming rising edge should do.
  task automatic step(input logic rd, input logic [63:0] ra,
                      input logic ak, input logic rdy,
                      input logic [31:0] dt);
    int   sz;
    logic e_val, e_stb, misq;
    ent_t h, n;
    @(negedge clk);
    reset_i = 1'b0;
    redir_i = rd; redir_adr_i = ra;
    iack_i = ak; inst_ready_i = rdy; idat_i = dt;
    #1;
    sz    = mq.size();
    e_val = (sz > 0);
    e_stb = !mhalt && sz < 4 && !rd && (mfpc[1:0] == 2'b00);
    misq  = !mhalt && sz < 4 && (mfpc[1:0] != 2'b00);
    h = '{d: 32'h0, a: 64'h0, f: 1'b0};
    if (e_val) h = mq[0];
    chk("valid", 64'(inst_valid_o), 64'(e_val));
    chk("count", 64'(count_o), 64'(sz));
    chk("istb", 64'(istb_o), 64'(e_stb));
    chk("iadr", iadr_o, e_stb ? mfpc : 64'h0);
    chk("isiz", 64'(isiz_o), e_stb ? 64'd2 : 64'd0);
    chk("fault", 64'(inst_fault_o), 64'(h.f));
    chk("inst", 64'(inst_o), h.f ? 64'h0 : 64'(h.d));
    chk("inst_adr", inst_adr_o, h.a);
    if (rd) begin
      mq.delete();
      mfpc  = ra;
      mhalt = 0;
    end else begin
      if (e_val && rdy) void'(mq.pop_front());
      if (e_stb && ak) begin
        n = '{d: dt, a: mfpc, f: 1'b0};
        mq.push_back(n);
        mfpc = mfpc + 64'd4;
      end else if (misq) begin
        n = '{d: 32'h0, a: mfpc, f: 1'b1};
        mq.push_back(n);
        mhalt = 1;
      end
    end
  endtask

  // Reset with the bus acking: the strobe must stay low throughout.
  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      reset_i = 1'b1; iack_i = 1'b1; inst_ready_i = 1'b1;
      redir_i = 1'b0; idat_i = 32'hBAD0_0000;
      #1;
      chk("istb_in_reset", 64'(istb_o), 64'h0);
    end
    model_reset();
  endtask

  typedef struct {
    logic        rd;
    logic [63:0] ra;
    logic        ak;
    logic        rdy;
    logic [31:0] dt;
    logic        stb;
    logic [63:0] adr;
    logic        val;
    logic [2:0]  cnt;
    logic        flt;
    logic [31:0] ins;
    logic [63:0] hadr;
  } vec_t;

  function automatic vec_t mk(logic rd, logic [63:0] ra, logic ak,
      logic rdy, logic [31:0] dt, logic stb, logic [63:0] adr,
      logic val, logic [2:0] cnt, logic flt, logic [31:0] ins,
      logic [63:0] hadr);
    vec_t v;
    v.rd = rd; v.ra = ra; v.ak = ak; v.rdy = rdy; v.dt = dt;
    v.stb = stb; v.adr = adr; v.val = val; v.cnt = cnt;
    v.flt = flt; v.ins = ins; v.hadr = hadr;
    return v;
  endfunction

  localparam logic [63:0] R = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [31:0] X = 32'hDEAD_BEEF;

  vec_t tbl[22];

  initial begin
    logic [31:0] d[7];
    for (int k = 0; k < 7; k++) d[k] = 32'h1000_0013 + 32'(k);

    tbl[0]  = mk(0, 0, 1, 0, d[0], 1, R,       0, 0, 0, 0,    0);
    tbl[1]  = mk(0, 0, 1, 0, d[1], 1, R+4,     1, 1, 0, d[0], R);
    tbl[2]  = mk(0, 0, 1, 0, d[2], 1, R+8,     1, 2, 0, d[0], R);
    tbl[3]  = mk(0, 0, 1, 0, d[3], 1, R+12,    1, 3, 0, d[0], R);
    tbl[4]  = mk(0, 0, 1, 0, X,    0, 0,       1, 4, 0, d[0], R);
    tbl[5]  = mk(0, 0, 1, 1, X,    0, 0,       1, 4, 0, d[0], R);
    tbl[6]  = mk(0, 0, 1, 0, d[4], 1, R+16,    1, 3, 0, d[1], R+4);
    tbl[7]  = mk(0, 0, 1, 1, X,    0, 0,       1, 4, 0, d[1], R+4);
    tbl[8]  = mk(0, 0, 1, 1, d[5], 1, R+20,    1, 3, 0, d[2], R+8);
    tbl[9]  = mk(0, 0, 1, 1, d[6], 1, R+24,    1, 3, 0, d[3], R+12);
    tbl[10] = mk(1, 64'h1000, 1, 1, X, 0, 0,   1, 3, 0, d[4], R+16);
    tbl[11] = mk(0, 0, 0, 0, X,    1, 64'h1000, 0, 0, 0, 0,   0);
    tbl[12] = mk(0, 0, 1, 0, 32'hE000_0013, 1, 64'h1000,
                 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, X,    1, 64'h1004, 1, 1, 0,
                 32'hE000_0013, 64'h1000);
    tbl[14] = mk(1, 64'h1002, 0, 0, X, 0, 0, 1, 1, 0,
                 32'hE000_0013, 64'h1000);
    tbl[15] = mk(0, 0, 0, 0, X,    0, 0,       0, 0, 0, 0,    0);
    tbl[16] = mk(0, 0, 1, 0, X,    0, 0,       1, 1, 1, 0, 64'h1002);
    tbl[17] = mk(0, 0, 1, 1, X,    0, 0,       1, 1, 1, 0, 64'h1002);
    tbl[18] = mk(0, 0, 1, 0, X,    0, 0,       0, 0, 0, 0,    0);
    tbl[19] = mk(1, 64'h2000, 1, 0, X, 0, 0,   0, 0, 0, 0,    0);
    tbl[20] = mk(0, 0, 1, 0, 32'hF000_0013, 1, 64'h2000,
                 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, X,    1, 64'h2004, 1, 1, 0,
                 32'hF000_0013, 64'h2000);

    do_reset();

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rd, tbl[i].ra, tbl[i].ak, tbl[i].rdy, tbl[i].dt);
      chk($sformatf("v%0d.istb", i), 64'(istb_o), 64'(tbl[i].stb));
      chk($sformatf("v%0d.iadr", i), iadr_o, tbl[i].adr);
      chk($sformatf("v%0d.valid", i), 64'(inst_valid_o),
          64'(tbl[i].val));
      chk($sformatf("v%0d.count", i), 64'(count_o), 64'(tbl[i].cnt));
      chk($sformatf("v%0d.fault", i), 64'(inst_fault_o),
          64'(tbl[i].flt));
      chk($sformatf("v%0d.inst", i), 64'(inst_o), 64'(tbl[i].ins));
      chk($sformatf("v%0d.hadr", i), inst_adr_o, tbl[i].hadr);
      if (i == 0) begin
        chk("x32.istb0", 64'(istb32), 64'h1);
        chk("x32.iadr0", 64'(iadr32), 64'hFFFF_FFFC);
      end
      if (i == 1) begin
        chk("x32.iadr1", 64'(iadr32), 64'h0);
        chk("x32.inst_adr1", 64'(adr32), 64'hFFFF_FFFC);
      end
      if (i == 2) begin
        chk("x32.full_istb", 64'(istb32), 64'h0);
        chk("x32.full_cnt", 64'(cnt32), 64'h2);
      end
    end

    for (int n = 0; n < 4000; n++) begin
      logic        rd;
      logic [63:0] ra;
      if (n == 2000) do_reset();
      rd = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 3))
        0:       ra = 64'hFFFF_FFFF_FFFF_FFF0;
        1:       ra = 64'h0000_0000_0000_1000;
        default: ra = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      step(rd, ra, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/polaris_ifetch_queue.md
Name: polaris_ifetch_queue

Overview:
- Parametrised instruction prefetch unit for the next-generation Polaris core; replaces the single-shot fetch (PC to IR) done inside the sequencer.
- Runs ahead of the execute sequencer on the I master bus and buffers up to DEPTH 32-bit instruction words, each tagged with its address.
- Accepts redirects (branch, jump, trap, mret, fence.i) that flush the queue and restart fetch at a new address.
- Detects misaligned fetch targets and reports them as tagged faults instead of issuing a bus cycle.

Parameters:
- XLEN, 64, address width in bits. Legal values: 32 or 64.
- DEPTH, 4, queue entries. Must be a power of two, at least 2.
- RESET_VEC, 64'hFFFF_FFFF_FFFF_FF00, fetch address after reset, truncated to XLEN.

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- iack_i  in  1  I-bus acknowledge; idat_i is valid in the same cycle.
- idat_i  in  32  I-bus read data.
- istb_o  out  1  I-bus request strobe.
- iadr_o  out  XLEN  I-bus address; forced to 0 when istb_o=0.
- isiz_o  out  2  2'b10 (word) when istb_o=1, else 2'b00.
- redir_i  in  1  flush the queue and restart fetch at redir_adr_i.
- redir_adr_i  in  XLEN  redirect target.
- inst_valid_o  out  1  queue head is valid.
- inst_ready_i  in  1  consumer accepts the head this cycle.
- inst_o  out  32  head instruction word; 0 when the head is invalid or a fault.
- inst_adr_o  out  XLEN  address of the head entry (feeds ia/mepc).
- inst_fault_o  out  1  head entry is an instruction-address-misaligned fault (mcause 0).
- count_o  out  $clog2(DEPTH)+1  current occupancy, for diagnostics.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset state: while reset_i is sampled high, at the next edge: fpc<=RESET_VEC, rd/wr pointers<=0, count<=0, state<=FETCH.
- Output values in and after reset: istb_o=0 during the reset cycle; inst_valid_o=0, inst_fault_o=0, count_o=0 after reset.
- Reset mid-bus-cycle: reset abandons any pending bus cycle; an iack_i arriving in the reset cycle is ignored.
- States:
  - FETCH: istb_o = (count<DEPTH) & ~redir_i & (fpc[1:0]==0); iadr_o=fpc.
  - HALT: istb_o=0.
- Bus handshake (Polaris style):
  - istb_o, iadr_o and isiz_o are held stable until iack_i.
  - Zero-wait ack (iack_i in the same cycle as istb_o) is legal.
  - On istb_o & iack_i: enqueue {idat_i, fpc, fault=0}; fpc<=fpc+4, wrapping modulo 2^XLEN.
  - At most one outstanding request.
- Misalignment: in FETCH with count<DEPTH and fpc[1:0]!=0, issue no bus cycle. Enqueue {0, fpc, fault=1} and go to HALT. Stay in HALT until redir_i.
- Dequeue: when inst_valid_o & inst_ready_i, rd pointer advances.
- Simultaneous enqueue and dequeue: count is unchanged, including when count==DEPTH-1 or when count==1.
- Full queue (count==DEPTH): istb_o stays low. No request starts until a dequeue lowers count; request start is evaluated on registered count.
- Empty queue: inst_valid_o=0 and inst_ready_i is ignored.
- Fetch latency: minimum is one cycle from enqueue edge to inst_valid_o, with no same-cycle bypass. From redirect to first valid is at least 2 cycles with zero-wait memory.
- Redirect (redir_i=1), highest priority:
  - Next edge: count<=0, pointers<=0, fpc<=redir_adr_i, state<=FETCH.
  - istb_o is forced low combinationally in the redirect cycle; an iack_i in that cycle is discarded.
  - A head accepted by inst_ready_i in the same cycle as redir_i counts as consumed by the consumer; the queue still flushes.
- Fault entries occupy a slot and dequeue normally.
- Pointers: wrap modulo DEPTH. count ranges 0..DEPTH, with no overflow or underflow under any input combination.

Test Plan:
- Reset with zero-wait iack_i tied high -> first istb_o with iadr_o=RESET_VEC one cycle after reset_i falls. Queue fills in 4 cycles to count_o=4. istb_o=0 when full.
- Consumer holds inst_ready_i=1 and memory returns 0x00000013 at each word -> one instruction per cycle. inst_adr_o steps by 4 from 0xFFFF_FFFF_FFFF_FF00. count_o steady.
- Queue full, a single dequeue -> count_o 4 to 3, then istb_o reasserts with iadr_o=head_adr+16.
- redir_i with redir_adr_i=0x1000 while istb_o is high and iack_i=1 -> that data is dropped, count_o=0 next cycle. Next request iadr_o=0x1000. First valid entry has inst_adr_o=0x1000.
- redir_adr_i=0x1002 -> no bus cycle. One entry appears with inst_fault_o=1, inst_o=0, inst_adr_o=0x1002. istb_o stays 0 until redir_i to 0x2000.
- XLEN=32, RESET_VEC=32'hFFFF_FFFC -> second fetch address wraps to 0x0000_0000.
